// File: rtl/decode_regread_unit_pkg.sv
// Shared definitions for the ID-stage decode / operand-read slice:
// MIPS-I opcode and funct codes, ALU control codes, HI/LO access encodings
// and the default geometry of the physical register file.
package decode_regread_unit_pkg;

    localparam int unsigned DEF_NUM_PREGS = 64;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned ALU_CTRL_W    = 6;
    localparam int unsigned MRA_W         = 2;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes with special handling
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    // REGIMM rt codes that link
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // ALU control codes for non-R-type instructions
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_ADDU = 6'h21;
    localparam logic [5:0] ALU_SUBU = 6'h23;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_XOR  = 6'h26;
    localparam logic [5:0] ALU_SLT  = 6'h2A;
    localparam logic [5:0] ALU_SLTU = 6'h2B;
    localparam logic [5:0] ALU_LUI  = 6'h0F;

    // mult_reg_access encodings: bit1 = HI, bit0 = LO
    localparam logic [1:0] MRA_NONE = 2'b00;
    localparam logic [1:0] MRA_LO   = 2'b01;
    localparam logic [1:0] MRA_HI   = 2'b10;
    localparam logic [1:0] MRA_BOTH = 2'b11;

    // R-type functs that are plain ALU operations (shifts, arithmetic, logic, compare)
    function automatic logic is_alu_funct(input logic [5:0] funct);
        case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: is_alu_funct = 1'b1;
            default:                    is_alu_funct = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_regread_unit_regfile.sv
// Physical register file: NUM_PREGS x DATA_W storage, one synchronous write
// port and two combinational read ports. Tag 0 is hardwired to zero.
// Ports: CLK, RESET (async active-low, clears all entries), STALL (blocks
// writes), wr_en/wr_preg/wr_data (write port), rs_preg/rs_value and
// rt_preg/rt_value (read ports, no write bypass).
module phys_regfile
    import decode_regread_unit_pkg::*;
#(
    parameter int unsigned NUM_PREGS = DEF_NUM_PREGS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    localparam int unsigned TAG_W    = $clog2(NUM_PREGS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_preg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  rs_preg,
    output logic [DATA_W-1:0] rs_value,
    input  logic [TAG_W-1:0]  rt_preg,
    output logic [DATA_W-1:0] rt_value
);

    logic [DATA_W-1:0] mem [NUM_PREGS];
    logic              wr_fire;

    assign wr_fire = wr_en && !STALL && (wr_preg != '0);

    // Storage; reset wins over a write in the same cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(NUM_PREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_fire) begin
            mem[wr_preg] <= wr_data;
        end
    end

    // Reads see stored state only, so a write shows up the next cycle
    assign rs_value = (rs_preg == '0) ? '0 : mem[rs_preg];
    assign rt_value = (rt_preg == '0) ? '0 : mem[rt_preg];

endmodule

// File: rtl/decode_regread_unit.sv
// ID-stage slice: full MIPS-I decode into control signals, branch/jump
// target calculation (both combinational) and the physical register file.
// Ports: CLK, RESET (async active-low, register file only), STALL,
// instr_in/instr_pc_in (instruction and its PC), decode outputs link..
// mult_reg_access, rs/rt read ports, wr_* write port, next_pc, jr_reg.
module decode_regread_unit
    import decode_regread_unit_pkg::*;
#(
    parameter int unsigned NUM_PREGS = DEF_NUM_PREGS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    localparam int unsigned TAG_W    = $clog2(NUM_PREGS)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  STALL,
    input  logic [INSTR_W-1:0]    instr_in,
    input  logic [INSTR_W-1:0]    instr_pc_in,
    output logic                  link,
    output logic                  reg_dest,
    output logic                  jump,
    output logic                  branch,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic                  jump_register,
    output logic                  sign_or_zero,
    output logic                  syscall,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [MRA_W-1:0]      mult_reg_access,
    input  logic [TAG_W-1:0]      rs_preg,
    input  logic [TAG_W-1:0]      rt_preg,
    output logic [DATA_W-1:0]     rs_value,
    output logic [DATA_W-1:0]     rt_value,
    input  logic                  wr_en,
    input  logic [TAG_W-1:0]      wr_preg,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [INSTR_W-1:0]    next_pc,
    output logic [4:0]            jr_reg
);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         rt_field;
    logic [INSTR_W-1:0] pc4;
    logic [INSTR_W-1:0] br_offset;

    assign opcode   = instr_in[31:26];
    assign funct    = instr_in[5:0];
    assign rt_field = instr_in[20:16];
    assign jr_reg   = instr_in[25:21];

    // Instruction decode; anything not recognised leaves every control at 0
    always_comb begin
        link            = 1'b0;
        reg_dest        = 1'b0;
        jump            = 1'b0;
        branch          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        alu_src         = 1'b0;
        reg_write       = 1'b0;
        jump_register   = 1'b0;
        sign_or_zero    = 1'b0;
        syscall         = 1'b0;
        alu_control     = '0;
        mult_reg_access = MRA_NONE;

        case (opcode)
            OP_RTYPE: begin
                // Recognised R-type functs target rd and pass funct to the ALU
                reg_dest    = 1'b1;
                alu_control = funct;
                case (funct)
                    FN_JR: begin
                        jump          = 1'b1;
                        jump_register = 1'b1;
                    end
                    FN_JALR: begin
                        jump          = 1'b1;
                        jump_register = 1'b1;
                        link          = 1'b1;
                        reg_write     = 1'b1;
                    end
                    FN_SYSCALL: begin
                        reg_dest    = 1'b0;
                        alu_control = '0;
                        syscall     = 1'b1;
                    end
                    FN_MFHI: begin
                        reg_write       = 1'b1;
                        mult_reg_access = MRA_HI;
                    end
                    FN_MFLO: begin
                        reg_write       = 1'b1;
                        mult_reg_access = MRA_LO;
                    end
                    FN_MTHI:  mult_reg_access = MRA_HI;
                    FN_MTLO:  mult_reg_access = MRA_LO;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                              mult_reg_access = MRA_BOTH;
                    default: begin
                        if (is_alu_funct(funct)) begin
                            reg_write = 1'b1;
                        end else begin
                            reg_dest    = 1'b0;
                            alu_control = '0;
                        end
                    end
                endcase
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump      = 1'b1;
                link      = 1'b1;
                reg_write = 1'b1;
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                branch       = 1'b1;
                sign_or_zero = 1'b1;
                alu_control  = ALU_SUBU;
                if (opcode == OP_REGIMM &&
                    (rt_field == RT_BLTZAL || rt_field == RT_BGEZAL)) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                alu_src      = 1'b1;
                reg_write    = 1'b1;
                sign_or_zero = 1'b1;
                case (opcode)
                    OP_ADDI:  alu_control = ALU_ADD;
                    OP_ADDIU: alu_control = ALU_ADDU;
                    OP_SLTI:  alu_control = ALU_SLT;
                    default:  alu_control = ALU_SLTU;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                case (opcode)
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    OP_XORI: alu_control = ALU_XOR;
                    default: alu_control = ALU_LUI;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                mem_read     = 1'b1;
                alu_src      = 1'b1;
                reg_write    = 1'b1;
                sign_or_zero = 1'b1;
                alu_control  = ALU_ADDU;
            end
            OP_SB, OP_SH, OP_SW: begin
                mem_write    = 1'b1;
                alu_src      = 1'b1;
                sign_or_zero = 1'b1;
                alu_control  = ALU_ADDU;
            end
            default: ;
        endcase
    end

    // Target calculation: register jump, region jump, or PC-relative branch
    assign pc4       = instr_pc_in + 32'd4;
    assign br_offset = {{14{instr_in[15]}}, instr_in[15:0], 2'b00};

    always_comb begin
        next_pc = pc4 + br_offset;
        if (jump && jump_register) begin
            next_pc = INSTR_W'(rs_value);
        end else if (jump) begin
            next_pc = {pc4[31:28], instr_in[25:0], 2'b00};
        end
    end

    phys_regfile #(
        .NUM_PREGS (NUM_PREGS),
        .DATA_W    (DATA_W)
    ) u_regfile (
        .CLK      (CLK),
        .RESET    (RESET),
        .STALL    (STALL),
        .wr_en    (wr_en),
        .wr_preg  (wr_preg),
        .wr_data  (wr_data),
        .rs_preg  (rs_preg),
        .rs_value (rs_value),
        .rt_preg  (rt_preg),
        .rt_value (rt_value)
    );

endmodule

// File: tb/tb_decode_regread_unit.sv
// Directed self-checking bench for decode_regread_unit.
module tb_decode_regread_unit;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic [31:0] instr_in;
    logic [31:0] instr_pc_in;
    logic        link, reg_dest, jump, branch, mem_read, mem_write;
    logic        alu_src, reg_write, jump_register, sign_or_zero, syscall;
    logic [5:0]  alu_control;
    logic [1:0]  mult_reg_access;
    logic [5:0]  rs_preg, rt_preg, wr_preg;
    logic [31:0] rs_value, rt_value, wr_data, next_pc;
    logic        wr_en;
    logic [4:0]  jr_reg;

    int errors = 0;
    int checks = 0;

    decode_regread_unit dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .STALL           (STALL),
        .instr_in        (instr_in),
        .instr_pc_in     (instr_pc_in),
        .link            (link),
        .reg_dest        (reg_dest),
        .jump            (jump),
        .branch          (branch),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .alu_src         (alu_src),
        .reg_write       (reg_write),
        .jump_register   (jump_register),
        .sign_or_zero    (sign_or_zero),
        .syscall         (syscall),
        .alu_control     (alu_control),
        .mult_reg_access (mult_reg_access),
        .rs_preg         (rs_preg),
        .rt_preg         (rt_preg),
        .rs_value        (rs_value),
        .rt_value        (rt_value),
        .wr_en           (wr_en),
        .wr_preg         (wr_preg),
        .wr_data         (wr_data),
        .next_pc         (next_pc),
        .jr_reg          (jr_reg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decode outputs packed in port order for whole-vector comparisons
    logic [18:0] dec_vec;
    assign dec_vec = {link, reg_dest, jump, branch, mem_read, mem_write, alu_src,
                      reg_write, jump_register, sign_or_zero, syscall,
                      alu_control, mult_reg_access};

    function automatic logic [18:0] dec(input bit l, input bit rd, input bit j,
                                        input bit b, input bit mr, input bit mw,
                                        input bit as, input bit rw, input bit jrg,
                                        input bit sz, input bit sc,
                                        input logic [5:0] ac, input logic [1:0] mra);
        dec = {l, rd, j, b, mr, mw, as, rw, jrg, sz, sc, ac, mra};
    endfunction

    task automatic test_reset();
        @(negedge CLK);
        #2 RESET = 1'b0;
        rs_preg = 6'd7;
        rt_preg = 6'd63;
        #1;
        checks++;
        if (rs_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_rs: got %h want %h", rs_value, 32'h0);
        end
        checks++;
        if (rt_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_rt: got %h want %h", rt_value, 32'h0);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_decode();
        // ADDU r3,r1,r2
        instr_in = 32'h0022_1821; instr_pc_in = 32'h0;
        #1;
        checks++;
        if (dec_vec !== dec(0,1,0,0,0,0,0,1,0,0,0,6'h21,2'b00)) begin
            errors++;
            $display("FAIL addu_dec: got %h want %h", dec_vec, dec(0,1,0,0,0,0,0,1,0,0,0,6'h21,2'b00));
        end
        // JAL 0x00400010 at PC 0x00400000
        instr_in = 32'h0C10_0004; instr_pc_in = 32'h0040_0000;
        #1;
        checks++;
        if (dec_vec !== dec(1,0,1,0,0,0,0,1,0,0,0,6'h00,2'b00)) begin
            errors++;
            $display("FAIL jal_dec: got %h want %h", dec_vec, dec(1,0,1,0,0,0,0,1,0,0,0,6'h00,2'b00));
        end
        checks++;
        if (next_pc !== 32'h0040_0010) begin
            errors++;
            $display("FAIL jal_pc: got %h want %h", next_pc, 32'h0040_0010);
        end
        // J near top of address space keeps pc4[31:28]
        instr_in = 32'h0800_0010; instr_pc_in = 32'hF000_0000;
        #1;
        checks++;
        if (next_pc !== 32'hF000_0040 || dec_vec !== dec(0,0,1,0,0,0,0,0,0,0,0,6'h00,2'b00)) begin
            errors++;
            $display("FAIL j_pc: got pc %h dec %h want pc %h", next_pc, dec_vec, 32'hF000_0040);
        end
        // BEQ with imm=-1 at PC 0x100 branches to itself
        instr_in = 32'h1000_FFFF; instr_pc_in = 32'h0000_0100;
        #1;
        checks++;
        if (dec_vec !== dec(0,0,0,1,0,0,0,0,0,1,0,6'h23,2'b00)) begin
            errors++;
            $display("FAIL beq_dec: got %h want %h", dec_vec, dec(0,0,0,1,0,0,0,0,0,1,0,6'h23,2'b00));
        end
        checks++;
        if (next_pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL beq_pc: got %h want %h", next_pc, 32'h0000_0100);
        end
        // BLTZAL +3 at PC 0x200
        instr_in = 32'h0410_0003; instr_pc_in = 32'h0000_0200;
        #1;
        checks++;
        if (dec_vec !== dec(1,0,0,1,0,0,0,1,0,1,0,6'h23,2'b00) || next_pc !== 32'h0000_0210) begin
            errors++;
            $display("FAIL bltzal: got dec %h pc %h want dec %h pc %h", dec_vec, next_pc,
                     dec(1,0,0,1,0,0,0,1,0,1,0,6'h23,2'b00), 32'h0000_0210);
        end
        // LW r2,4(r1)
        instr_in = 32'h8C22_0004;
        #1;
        checks++;
        if (dec_vec !== dec(0,0,0,0,1,0,1,1,0,1,0,6'h21,2'b00)) begin
            errors++;
            $display("FAIL lw_dec: got %h want %h", dec_vec, dec(0,0,0,0,1,0,1,1,0,1,0,6'h21,2'b00));
        end
        // SW r2,4(r1)
        instr_in = 32'hAC22_0004;
        #1;
        checks++;
        if (dec_vec !== dec(0,0,0,0,0,1,1,0,0,1,0,6'h21,2'b00)) begin
            errors++;
            $display("FAIL sw_dec: got %h want %h", dec_vec, dec(0,0,0,0,0,1,1,0,0,1,0,6'h21,2'b00));
        end
        // ORI zero-extends
        instr_in = 32'h3422_0005;
        #1;
        checks++;
        if (dec_vec !== dec(0,0,0,0,0,0,1,1,0,0,0,6'h25,2'b00)) begin
            errors++;
            $display("FAIL ori_dec: got %h want %h", dec_vec, dec(0,0,0,0,0,0,1,1,0,0,0,6'h25,2'b00));
        end
        // ADDI sign-extends
        instr_in = 32'h2022_0005;
        #1;
        checks++;
        if (dec_vec !== dec(0,0,0,0,0,0,1,1,0,1,0,6'h20,2'b00)) begin
            errors++;
            $display("FAIL addi_dec: got %h want %h", dec_vec, dec(0,0,0,0,0,0,1,1,0,1,0,6'h20,2'b00));
        end
        // MULT: HI and LO, no GPR write
        instr_in = 32'h0022_0018;
        #1;
        checks++;
        if (mult_reg_access !== 2'b11 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL mult: got access %b rw %b want 11 0", mult_reg_access, reg_write);
        end
        // MFLO r3: LO read, GPR write
        instr_in = 32'h0000_1812;
        #1;
        checks++;
        if (mult_reg_access !== 2'b01 || reg_write !== 1'b1) begin
            errors++;
            $display("FAIL mflo: got access %b rw %b want 01 1", mult_reg_access, reg_write);
        end
        // SYSCALL: only syscall
        instr_in = 32'h0000_000C;
        #1;
        checks++;
        if (dec_vec !== dec(0,0,0,0,0,0,0,0,0,0,1,6'h00,2'b00)) begin
            errors++;
            $display("FAIL syscall_dec: got %h want %h", dec_vec, dec(0,0,0,0,0,0,0,0,0,0,1,6'h00,2'b00));
        end
        // Unused opcode 0x3F
        instr_in = 32'hFC00_0000;
        #1;
        checks++;
        if (dec_vec !== 19'h0) begin
            errors++;
            $display("FAIL illegal_dec: got %h want %h", dec_vec, 19'h0);
        end
    endtask

    task automatic test_stall_write();
        @(negedge CLK);
        STALL = 1'b1; wr_en = 1'b1; wr_preg = 6'd7; wr_data = 32'h0000_1234;
        rt_preg = 6'd7;
        @(posedge CLK); #1;
        checks++;
        if (rt_value !== 32'h0) begin
            errors++;
            $display("FAIL stall_write: got %h want %h", rt_value, 32'h0);
        end
        @(negedge CLK);
        STALL = 1'b0;
        #1;
        checks++;
        if (rt_value !== 32'h0) begin
            errors++;
            $display("FAIL no_bypass: got %h want %h", rt_value, 32'h0);
        end
        @(posedge CLK); #1;
        checks++;
        if (rt_value !== 32'h0000_1234) begin
            errors++;
            $display("FAIL write_visible: got %h want %h", rt_value, 32'h0000_1234);
        end
        // Write to preg 0 is discarded
        @(negedge CLK);
        wr_preg = 6'd0; wr_data = 32'hFFFF_FFFF; rs_preg = 6'd0;
        @(posedge CLK); #1;
        checks++;
        if (rs_value !== 32'h0) begin
            errors++;
            $display("FAIL preg0: got %h want %h", rs_value, 32'h0);
        end
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic test_jr();
        @(negedge CLK);
        wr_en = 1'b1; wr_preg = 6'd5; wr_data = 32'hDEAD_BEEF;
        @(negedge CLK);
        wr_en = 1'b0;
        rs_preg = 6'd5;
        instr_in = 32'h00A0_0008; instr_pc_in = 32'h0000_1000;
        #1;
        checks++;
        if (jump !== 1'b1 || jump_register !== 1'b1 || reg_write !== 1'b0 || link !== 1'b0) begin
            errors++;
            $display("FAIL jr_dec: got j %b jrg %b rw %b l %b want 1 1 0 0", jump, jump_register, reg_write, link);
        end
        checks++;
        if (next_pc !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL jr_pc: got %h want %h", next_pc, 32'hDEAD_BEEF);
        end
        checks++;
        if (jr_reg !== 5'd5) begin
            errors++;
            $display("FAIL jr_reg: got %h want %h", jr_reg, 5'd5);
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge CLK);
        wr_en = 1'b1; wr_preg = 6'd9; wr_data = 32'h0000_A5A5;
        @(negedge CLK);
        wr_en = 1'b0;
        rs_preg = 6'd7; rt_preg = 6'd9;
        #1;
        checks++;
        if (rt_value !== 32'h0000_A5A5) begin
            errors++;
            $display("FAIL pre_reset_rd: got %h want %h", rt_value, 32'h0000_A5A5);
        end
        #1 RESET = 1'b0;
        #1;
        checks++;
        if (rs_value !== 32'h0 || rt_value !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset: got rs %h rt %h want 0 0", rs_value, rt_value);
        end
        // A write attempted while reset is held is lost
        wr_en = 1'b1; wr_preg = 6'd9; wr_data = 32'h0000_0055;
        @(posedge CLK); #1;
        @(negedge CLK);
        RESET = 1'b1; wr_en = 1'b0;
        #1;
        checks++;
        if (rt_value !== 32'h0) begin
            errors++;
            $display("FAIL write_in_reset: got %h want %h", rt_value, 32'h0);
        end
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0;
        instr_in = '0; instr_pc_in = '0;
        rs_preg = '0; rt_preg = '0;
        wr_en = 1'b0; wr_preg = '0; wr_data = '0;
        test_reset();
        test_decode();
        test_stall_write();
        test_jr();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
